time_set_ctrl: RTL and testbench

Mode controller that sequences the clock's time-set datapath. It turns three synchronized push-button levels into a set-mode state machine: hour edit, minute edit, then commit. It keeps a BCD edit copy of HH:MM with wrap-around up/down stepping and issues a one-cycle load strobe to the running timekeeper. It sits between the button synchronizers and the HH:MM counter/display path and replaces ad-hoc per-digit increment wiring.

---
 rtl/time_set_ctrl.sv | 173 +++++++++++++++++
 tb/tb_time_set_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/time_set_ctrl.sv
// Set-mode controller for the HH:MM timekeeper: hour edit, minute edit, commit.
// Optional inactivity abort is built when TIME_SET_TIMEOUT_EN is defined.
module time_set_ctrl #(
    parameter int TIMEOUT_CYC = 30,
    parameter int TW          = 5
) (
    input  logic       clk_1,
    input  logic       rst_n,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic [3:0] cur_h1,
    input  logic [3:0] cur_h2,
    input  logic [3:0] cur_m1,
    input  logic [3:0] cur_m2,
    output logic       set,
    output logic [1:0] field_sel,
    output logic [3:0] e_h1,
    output logic [3:0] e_h2,
    output logic [3:0] e_m1,
    output logic [3:0] e_m2,
    output logic       load,
    output logic       abort
);

    // state     | meaning
    // RUN       | normal timekeeping, edit copy idle
    // EDIT_HOUR | up/down step the hour field
    // EDIT_MIN  | up/down step the minute field
    // COMMIT    | one cycle, load strobe to the timekeeper
    typedef enum logic [1:0] {RUN, EDIT_HOUR, EDIT_MIN, COMMIT} state_t;

    state_t state;
    logic   mode_q, up_q, down_q;
    logic   mode_e, up_e, down_e, step_up, step_dn;
    logic   in_edit, accept, timeout;

    // 23 -> 00 wrap and any illegal value both land on 00
    function automatic logic [7:0] hour_inc(input logic [3:0] t, input logic [3:0] u);
        logic [7:0] r;
        if (t > 4'd2 || u > 4'd9 || (t == 4'd2 && u >= 4'd3)) r = 8'h00;
        else if (u == 4'd9)                                    r = {t + 4'd1, 4'd0};
        else                                                   r = {t, u + 4'd1};
        return r;
    endfunction

    function automatic logic [7:0] hour_dec(input logic [3:0] t, input logic [3:0] u);
        logic [7:0] r;
        if (t > 4'd2 || u > 4'd9 || (t == 4'd2 && u > 4'd3) || (t == 4'd0 && u == 4'd0))
            r = 8'h23;
        else if (u == 4'd0) r = {t - 4'd1, 4'd9};
        else                r = {t, u - 4'd1};
        return r;
    endfunction

    function automatic logic [7:0] min_inc(input logic [3:0] t, input logic [3:0] u);
        logic [7:0] r;
        if (t > 4'd5 || u > 4'd9 || (t == 4'd5 && u == 4'd9)) r = 8'h00;
        else if (u == 4'd9)                                    r = {t + 4'd1, 4'd0};
        else                                                   r = {t, u + 4'd1};
        return r;
    endfunction

    function automatic logic [7:0] min_dec(input logic [3:0] t, input logic [3:0] u);
        logic [7:0] r;
        if (t > 4'd5 || u > 4'd9 || (t == 4'd0 && u == 4'd0)) r = 8'h59;
        else if (u == 4'd0)                                    r = {t - 4'd1, 4'd9};
        else                                                   r = {t, u - 4'd1};
        return r;
    endfunction

    assign mode_e  = btn_mode & ~mode_q;
    assign up_e    = btn_up   & ~up_q;
    assign down_e  = btn_down & ~down_q;
    assign step_up = up_e & ~down_e;
    assign step_dn = down_e & ~up_e;
    assign in_edit = (state == EDIT_HOUR) || (state == EDIT_MIN);
    assign accept  = in_edit & (mode_e | step_up | step_dn);

`ifdef TIME_SET_TIMEOUT_EN
    // Down-counter reloaded on activity; reaching zero means TIMEOUT_CYC-1 idle cycles
    localparam logic [TW-1:0] IDLE_LOAD = TW'(TIMEOUT_CYC - 2);
    logic [TW-1:0] idle_cnt;

    always_ff @(posedge clk_1 or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if ((state == RUN && mode_e) || accept) begin
            idle_cnt <= IDLE_LOAD;
        end else if (in_edit && idle_cnt != '0) begin
            idle_cnt <= idle_cnt - 1'b1;
        end
    end

    assign timeout = in_edit & ~accept & (idle_cnt == '0);
`else
    // Timing parameters have no effect here; the expression is constant 0
    assign timeout = (TIMEOUT_CYC < 0) || (TW < 0);
`endif

    always_ff @(posedge clk_1 or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            mode_q    <= 1'b1;
            up_q      <= 1'b1;
            down_q    <= 1'b1;
            set       <= 1'b0;
            field_sel <= 2'd0;
            e_h1      <= 4'd0;
            e_h2      <= 4'd0;
            e_m1      <= 4'd0;
            e_m2      <= 4'd0;
            load      <= 1'b0;
            abort     <= 1'b0;
        end else begin
            mode_q <= btn_mode;
            up_q   <= btn_up;
            down_q <= btn_down;
            load   <= 1'b0;
            abort  <= 1'b0;
            case (state)
                RUN: begin
                    if (mode_e) begin
                        state     <= EDIT_HOUR;
                        set       <= 1'b1;
                        field_sel <= 2'd1;
                        e_h1      <= cur_h1;
                        e_h2      <= cur_h2;
                        e_m1      <= cur_m1;
                        e_m2      <= cur_m2;
                    end
                end
                EDIT_HOUR: begin
                    if (mode_e) begin
                        state     <= EDIT_MIN;
                        field_sel <= 2'd2;
                    end else if (step_up) begin
                        {e_h1, e_h2} <= hour_inc(e_h1, e_h2);
                    end else if (step_dn) begin
                        {e_h1, e_h2} <= hour_dec(e_h1, e_h2);
                    end else if (timeout) begin
                        state     <= RUN;
                        set       <= 1'b0;
                        field_sel <= 2'd0;
                        abort     <= 1'b1;
                    end
                end
                EDIT_MIN: begin
                    if (mode_e) begin
                        state     <= COMMIT;
                        field_sel <= 2'd0;
                        load      <= 1'b1;
                    end else if (step_up) begin
                        {e_m1, e_m2} <= min_inc(e_m1, e_m2);
                    end else if (step_dn) begin
                        {e_m1, e_m2} <= min_dec(e_m1, e_m2);
                    end else if (timeout) begin
                        state     <= RUN;
                        set       <= 1'b0;
                        field_sel <= 2'd0;
                        abort     <= 1'b1;
                    end
                end
                default: begin
                    state     <= RUN;
                    set       <= 1'b0;
                    field_sel <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: directed scenarios plus random button traffic vs. an arithmetic model.
module tb_time_set_ctrl;
    localparam int TC = 30;

    logic       clk_1    = 1'b0;
    logic       rst_n    = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_up   = 1'b0;
    logic       btn_down = 1'b0;
    logic [3:0] cur_h1 = 4'd1, cur_h2 = 4'd2, cur_m1 = 4'd3, cur_m2 = 4'd4;
    logic       set, load, abort;
    logic [1:0] field_sel;
    logic [3:0] e_h1, e_h2, e_m1, e_m2;

    time_set_ctrl #(.TIMEOUT_CYC(TC), .TW(5)) dut (
        .clk_1(clk_1), .rst_n(rst_n),
        .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
        .cur_h1(cur_h1), .cur_h2(cur_h2), .cur_m1(cur_m1), .cur_m2(cur_m2),
        .set(set), .field_sel(field_sel),
        .e_h1(e_h1), .e_h2(e_h2), .e_m1(e_m1), .e_m2(e_m2),
        .load(load), .abort(abort)
    );

    always #5 clk_1 = ~clk_1;

    int checks   = 0;
    int failures = 0;

    logic [20:0] dut_v;
    assign dut_v = {set, field_sel, e_h1, e_h2, e_m1, e_m2, load, abort};

    task automatic chk(input string name, input logic [20:0] act, input logic [20:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (set,fsel,HHMM,load,abort) t=%0t",
                     name, act, exp, $time);
        end
    endtask

    // Model: mode 0=run 1=hour 2=minute 3=commit; field values as plain integers
    int          m_mode;
    logic [3:0]  m_e [4];
    bit          m_abort;
    int          m_idle;
    bit          pm, pu, pd;

    function automatic logic [7:0] step_field(input logic [3:0] t, input logic [3:0] u,
                                              input int mx, input bit up);
        int v;
        bit legal;
        v = int'(t) * 10 + int'(u);
        legal = (t <= 4'd9) && (u <= 4'd9) && (v <= mx);
        if (!legal)  v = up ? 0 : mx;
        else if (up) v = (v + 1) % (mx + 1);
        else         v = (v + mx) % (mx + 1);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    always @(posedge clk_1 or negedge rst_n) begin
        if (!rst_n) begin
            m_mode  = 0;
            m_e     = '{default: 4'd0};
            m_abort = 0;
            m_idle  = 0;
            pm = 1; pu = 1; pd = 1;
        end else begin
            bit me, ue, de;
            logic [7:0] f;
            me = btn_mode && !pm;
            ue = btn_up && !pu;
            de = btn_down && !pd;
            pm = btn_mode; pu = btn_up; pd = btn_down;
            m_abort = 0;
            case (m_mode)
                0: if (me) begin
                    m_mode = 1;
                    m_e[0] = cur_h1; m_e[1] = cur_h2; m_e[2] = cur_m1; m_e[3] = cur_m2;
                    m_idle = 0;
                end
                1, 2: begin
                    if (me) begin
                        m_mode = m_mode + 1;
                        m_idle = 0;
                    end else if (ue != de) begin
                        if (m_mode == 1) begin
                            f = step_field(m_e[0], m_e[1], 23, ue);
                            m_e[0] = f[7:4]; m_e[1] = f[3:0];
                        end else begin
                            f = step_field(m_e[2], m_e[3], 59, ue);
                            m_e[2] = f[7:4]; m_e[3] = f[3:0];
                        end
                        m_idle = 0;
                    end else begin
                        m_idle = m_idle + 1;
`ifdef TIME_SET_TIMEOUT_EN
                        if (m_idle == TC - 1) begin
                            m_mode  = 0;
                            m_abort = 1;
                        end
`endif
                    end
                end
                default: m_mode = 0;
            endcase
        end
    end

    function automatic logic [20:0] exp_vec();
        logic [1:0] fs;
        fs = (m_mode == 1) ? 2'd1 : (m_mode == 2) ? 2'd2 : 2'd0;
        return {m_mode != 0, fs, m_e[0], m_e[1], m_e[2], m_e[3], m_mode == 3, m_abort};
    endfunction

    always @(negedge clk_1) chk("cycle", dut_v, exp_vec());

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk_1);
        #1;
    endtask

    // Returns one step after the edge that samples the press, so results are visible
    task automatic press(input bit m, input bit u, input bit d);
        btn_mode = 0; btn_up = 0; btn_down = 0;
        tick();
        btn_mode = m; btn_up = u; btn_down = d;
        tick();
        btn_mode = 0; btn_up = 0; btn_down = 0;
    endtask

    task automatic set_cur(input logic [15:0] v);
        {cur_h1, cur_h2, cur_m1, cur_m2} = v;
    endtask

    initial begin
        int r;
        set_cur(16'h1234);
        tick(2);
        chk("reset_values", dut_v, 21'd0);
        rst_n = 1;
        tick();
        press(1, 0, 0);
        chk("mode_enter", dut_v, {1'b1, 2'd1, 16'h1234, 1'b0, 1'b0});
        press(1, 0, 0);
        chk("to_edit_min", dut_v, {1'b1, 2'd2, 16'h1234, 1'b0, 1'b0});
        press(1, 0, 0);
        chk("commit_load", dut_v, {1'b1, 2'd0, 16'h1234, 1'b1, 1'b0});
        tick();
        chk("commit_done", dut_v, {1'b0, 2'd0, 16'h1234, 1'b0, 1'b0});

        set_cur(16'h2300);
        press(1, 0, 0);
        press(0, 1, 0);
        chk("hour_wrap_up", dut_v, {1'b1, 2'd1, 16'h0000, 1'b0, 1'b0});
        press(1, 0, 0);
        press(0, 0, 1);
        chk("min_wrap_down", dut_v, {1'b1, 2'd2, 16'h0059, 1'b0, 1'b0});
        press(1, 0, 0);
        chk("commit_0059", dut_v, {1'b1, 2'd0, 16'h0059, 1'b1, 1'b0});
        tick();
        chk("load_one_cycle", dut_v, {1'b0, 2'd0, 16'h0059, 1'b0, 1'b0});

        set_cur(16'h1009);
        press(1, 0, 0);
        press(1, 0, 0);
        press(0, 1, 0);
        chk("min_carry", dut_v, {1'b1, 2'd2, 16'h1010, 1'b0, 1'b0});
        press(0, 0, 1);
        chk("min_borrow", dut_v, {1'b1, 2'd2, 16'h1009, 1'b0, 1'b0});
        press(0, 1, 1);
        chk("up_down_same", dut_v, {1'b1, 2'd2, 16'h1009, 1'b0, 1'b0});
        press(0, 1, 0);
`ifdef TIME_SET_TIMEOUT_EN
        tick(TC - 2);
        chk("before_timeout", dut_v, {1'b1, 2'd2, 16'h1010, 1'b0, 1'b0});
        tick();
        chk("abort_pulse", dut_v, {1'b0, 2'd0, 16'h1010, 1'b0, 1'b1});
        tick();
        chk("abort_one_cycle", dut_v, {1'b0, 2'd0, 16'h1010, 1'b0, 1'b0});
`else
        tick(100);
        chk("no_timeout", dut_v, {1'b1, 2'd2, 16'h1010, 1'b0, 1'b0});
        press(1, 0, 0);
        tick();
`endif

        set_cur(16'h2567);
        press(1, 0, 0);
        press(0, 0, 1);
        chk("illegal_hour_down", dut_v, {1'b1, 2'd1, 16'h2367, 1'b0, 1'b0});
        press(1, 0, 0);
        press(0, 1, 0);
        chk("illegal_min_up", dut_v, {1'b1, 2'd2, 16'h2300, 1'b0, 1'b0});
        press(1, 0, 0);
        tick();

        set_cur(16'h0745);
        rst_n = 0;
        btn_mode = 1;
        tick(2);
        rst_n = 1;
        tick(3);
        chk("held_through_reset", dut_v, 21'd0);
        press(1, 0, 0);
        chk("press_after_release", dut_v, {1'b1, 2'd1, 16'h0745, 1'b0, 1'b0});
        press(1, 0, 0);
        chk("edit_min_0745", dut_v, {1'b1, 2'd2, 16'h0745, 1'b0, 1'b0});
        #2 rst_n = 0;
        #1 chk("reset_mid_edit", dut_v, 21'd0);
        tick(2);
        rst_n = 1;
        tick();

        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(0, 999);
            if (r < 3) begin
                rst_n = 0;
                tick();
                rst_n = 1;
            end else if (r < 13) begin
                btn_mode = 0; btn_up = 0; btn_down = 0;
                tick(TC + 5);
            end else begin
                if ($urandom_range(0, 9) == 0) btn_mode = ~btn_mode;
                if ($urandom_range(0, 4) == 0) btn_up   = ~btn_up;
                if ($urandom_range(0, 4) == 0) btn_down = ~btn_down;
                if ($urandom_range(0, 19) == 0) begin
                    if ($urandom_range(0, 7) == 0) begin
                        cur_h1 = 4'($urandom_range(0, 15));
                        cur_h2 = 4'($urandom_range(0, 15));
                        cur_m1 = 4'($urandom_range(0, 15));
                        cur_m2 = 4'($urandom_range(0, 15));
                    end else begin
                        int h, m;
                        h = $urandom_range(0, 23);
                        m = $urandom_range(0, 59);
                        cur_h1 = 4'(h / 10); cur_h2 = 4'(h % 10);
                        cur_m1 = 4'(m / 10); cur_m2 = 4'(m % 10);
                    end
                end
                tick();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
